// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE dot-product sequencer.
// Pipeline depths here set how long the sequencer waits for in-flight terms.
package pe_ctrl_pkg;

    localparam int ACC_W   = 32;
    localparam int DATA_W  = 8;
    localparam int RD_LAT  = 1;
    localparam int PE_LAT  = 1;
    localparam int DRAIN_D = RD_LAT + PE_LAT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/pe_addr_gen.sv
// Base+counter address generator shared by the ifmap and weight buffers.
// One counter walks both buffers; first/last flag the term boundaries.
module pe_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic              step,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              first,
    output logic              last
);

    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            len_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (load) begin
            cnt   <= '0;
            len_q <= len;
            a_q   <= a_base;
            b_q   <= b_base;
        end else if (step) begin
            cnt <= cnt + LEN_W'(1);
        end
    end

    // Truncating the sum to ADDR_W bits gives the wrap-around for free.
    assign a_addr = a_q + cnt[ADDR_W-1:0];
    assign b_addr = b_q + cnt[ADDR_W-1:0];
    assign first  = (cnt == '0);
    assign last   = (cnt == len_q - LEN_W'(1));

endmodule

// File: rtl/pe_dot_sequencer.sv
// Streams L ifmap/weight pairs through one PE, injects bias on term 0 and
// accumulates the PE results into a single 32-bit valid/ready output.
module pe_dot_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] if_base,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ACC_W-1:0]  bias_in,
    output logic              busy,
    output logic              done,
    output logic              if_rd_en,
    output logic [ADDR_W-1:0] if_rd_addr,
    input  logic [DATA_W-1:0] if_rd_data,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [DATA_W-1:0] w_rd_data,
    output logic              pe_en,
    output logic [DATA_W-1:0] pe_ifmap,
    output logic [DATA_W-1:0] pe_weight,
    output logic [ACC_W-1:0]  pe_bias,
    input  logic [ACC_W-1:0]  pe_opsum,
    input  logic              pe_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data
);

    state_t state, state_nxt;

    logic              load;
    logic              rd_en;
    logic              rd_first;
    logic              rd_last;
    logic [ADDR_W-1:0] if_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  bias_q;
    // Issued reads that have not yet reached the PE output stage.
    logic [DRAIN_D-2:0] inflight;
    logic [RD_LAT-1:0]  first_pipe;
    logic               pipe_clear;

    pe_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .len    (len),
        .a_base (if_base),
        .b_base (w_base),
        .step   (rd_en),
        .a_addr (if_addr),
        .b_addr (w_addr),
        .first  (rd_first),
        .last   (rd_last)
    );

    assign rd_en      = (state == RUN);
    assign pipe_clear = (inflight == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (len == '0) ? OUT : RUN;
                end
            end
            RUN:   if (rd_last)    state_nxt = DRAIN;
            DRAIN: if (pipe_clear) state_nxt = OUT;
            OUT:   if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= '0;
            first_pipe <= '0;
        end else begin
            inflight[0]   <= rd_en;
            first_pipe[0] <= rd_en && rd_first;
            for (int i = 1; i < DRAIN_D - 1; i++) inflight[i] <= inflight[i-1];
            for (int i = 1; i < RD_LAT; i++)      first_pipe[i] <= first_pipe[i-1];
        end
    end

    // A zero-length job never touches the PE, so the bias goes straight into acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            bias_q <= '0;
        end else if (load) begin
            bias_q <= bias_in;
            acc    <= (len == '0) ? bias_in : '0;
        end else if (pe_valid && (state == RUN || state == DRAIN)) begin
            acc <= acc + pe_opsum;
        end
    end

    assign if_rd_en   = rd_en;
    assign w_rd_en    = rd_en;
    assign if_rd_addr = rd_en ? if_addr : '0;
    assign w_rd_addr  = rd_en ? w_addr  : '0;

    assign pe_en     = inflight[RD_LAT-1];
    assign pe_ifmap  = if_rd_data;
    assign pe_weight = w_rd_data;
    assign pe_bias   = (pe_en && first_pipe[RD_LAT-1]) ? bias_q : '0;

    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);
    assign out_data  = out_valid ? acc : '0;
    assign done      = out_valid && out_ready;

endmodule

// File: doc/pe_dot_sequencer.md
Name: pe_dot_sequencer

Overview:
Sequences one PE through a length-L dot product. It streams ifmap and weight bytes out of two on-chip buffers that have 1-cycle read latency. It injects the bias on the first term only, accumulates the PE's registered partial sums, and presents one 32-bit result through a valid/ready handshake. It sits between the layer controller (start/done) and the PE/buffer datapath.

Parameters:
ADDR_W, 10, buffer address width (max 2^ADDR_W elements per buffer)
LEN_W, 11, width of the length field (allows L up to 2^ADDR_W)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; also resets the PE
start  in  1  1-cycle command strobe; sampled only in IDLE
len  in  LEN_W  number of terms L, sampled with start
if_base  in  ADDR_W  ifmap buffer start address, sampled with start
w_base  in  ADDR_W  weight buffer start address, sampled with start
bias_in  in  32  signed bias, sampled with start
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse on the output handshake
if_rd_en  out  1  ifmap buffer read enable
if_rd_addr  out  ADDR_W  ifmap read address
if_rd_data  in  8  ifmap data, valid 1 cycle after if_rd_en
w_rd_en  out  1  weight buffer read enable
w_rd_addr  out  ADDR_W  weight read address
w_rd_data  in  8  weight data, valid 1 cycle after w_rd_en
pe_en  out  1  PE enable
pe_ifmap  out  8  equals if_rd_data
pe_weight  out  8  equals w_rd_data
pe_bias  out  32  bias for the current PE term
pe_opsum  in  32  PE registered result
pe_valid  in  1  PE result valid (1 cycle after pe_en)
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  32  accumulated result

Behaviour:
- Reset values: every output is 0. The FSM goes to IDLE. Counters, accumulator and captured fields clear.
- FSM states: IDLE, RUN, DRAIN, OUT.
  - IDLE -> RUN on start with len != 0.
  - IDLE -> OUT on start with len == 0. In this case acc is loaded with bias_in, so out_data = bias_in.
  - RUN -> DRAIN after L reads have been issued.
  - DRAIN -> OUT when the pipeline holds no outstanding terms, i.e. the last pe_valid has been accumulated.
  - OUT -> IDLE when out_valid && out_ready.
- RUN timing:
  - With start sampled at edge E0, read k (k = 0..L-1) is issued in cycle k+1.
  - if_rd_en = w_rd_en = 1 during those cycles.
  - Read addresses are if_base+k and w_base+k, wrapping mod 2^ADDR_W.
- PE drive:
  - pe_en is the 1-cycle-delayed read-issue flag.
  - pe_ifmap and pe_weight are the raw buffer data; the sequencer does no sign handling.
  - pe_bias = captured bias when pe_en is high for term 0; 0 for every other term and whenever pe_en is low.
- Accumulation:
  - acc clears on start.
  - On each pe_valid, acc <= acc + pe_opsum, modulo 2^32 with no saturation.
  - pe_valid is ignored in IDLE and OUT.
- Latency: out_valid rises in cycle L+3 after E0 (cycle 1 when L == 0). Throughput is 1 term per cycle with no bubbles.
- OUT handshake:
  - out_valid and out_data stay stable until out_ready.
  - done pulses in the cycle the handshake completes.
  - busy drops the following cycle.
- start is ignored while busy. A start in the same cycle the FSM returns to IDLE is not accepted; the earliest accepted start is the next IDLE cycle.
- Reset mid-operation aborts the job:
  - No done pulse and no out_valid.
  - Pending PE results are discarded, since the PE shares rst.

Decomposition:
- Shared package pe_ctrl_pkg holds:
  - the FSM state enum (IDLE/RUN/DRAIN/OUT);
  - ACC_W = 32 and DATA_W = 8;
  - RD_LAT = 1 and PE_LAT = 1, from which the drain depth is derived.
- One natural sub-module: pe_addr_gen, the base+counter address generator with terminal-count flag, instantiated once and shared by both buffers.

Test Plan:
- L=4, ifmap buffer {1,2,3,4}, weights {2,2,2,2}, bias=10 -> out_data=30, out_valid in cycle 7 after start, exactly 4 pe_en cycles, pe_bias=10 only on the first term.
- L=0, bias=-5 -> no buffer reads, no pe_en, out_valid in cycle 1 with out_data=0xFFFFFFFB, done on handshake.
- if_base=1022, w_base=1023, L=3 (ADDR_W=10) -> if_rd_addr sequence 1022,1023,0 and w_rd_addr sequence 1023,0,1.
- out_ready held low 5 cycles in OUT -> out_valid and out_data stable throughout; start pulses during that time are ignored; done exactly once.
- Accumulator wrap: bias=0x7FFFFFFF, L=1, ifmap 0x01, weight 0x01 -> out_data=0x80000000.
- rst asserted in RUN at term 2 of L=8 -> all outputs 0 next cycle, no done; a fresh start with L=2, {3,4}·{5,6}, bias=0 -> out_data=39.
